// File: rtl/sbox_layer_seq.sv
// Substitution-layer sequencer: streams the cipher state through LANES external
// 4-bit S-box lanes, one group of nibbles per cycle, least-significant group first.
module sbox_layer_seq #(
   parameter int unsigned STATE_W = 64,
   parameter int unsigned LANES   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [STATE_W-1:0]   in_state,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [STATE_W-1:0]   out_state,
   output logic                 sb_en,
   output logic [4*LANES-1:0]   sb_orig,
   input  logic [4*LANES-1:0]   sb_subst,
   output logic                 busy
);

   localparam int unsigned SW     = 4 * LANES;
   localparam int unsigned GROUPS = STATE_W / SW;
   // Counter is at least one bit wide so GROUPS=1 still has a legal vector.
   localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             fsm_q, fsm_d;
   logic [GW-1:0]      g_q, g_d;
   logic [STATE_W-1:0] st_q, st_d;
   logic [STATE_W-1:0] out_state_q, out_state_d;

   // State registers; async reset clears everything so lane inputs go quiet at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= StIdle;
         g_q         <= '0;
         st_q        <= '0;
         out_state_q <= '0;
      end else begin
         fsm_q       <= fsm_d;
         g_q         <= g_d;
         st_q        <= st_d;
         out_state_q <= out_state_d;
      end
   end

   // Next-state logic and FSM-decoded outputs.
   always_comb begin
      fsm_d       = fsm_q;
      g_d         = g_q;
      st_d        = st_q;
      out_state_d = out_state_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      sb_en       = 1'b0;
      sb_orig     = '0;
      case (fsm_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) begin
               st_d  = in_state;
               g_d   = '0;
               fsm_d = StRun;
            end
         end
         StRun: begin
            sb_en                     = 1'b1;
            sb_orig                   = st_q[int'(g_q) * SW +: SW];
            st_d[int'(g_q) * SW +: SW] = sb_subst;
            if (g_q == GW'(GROUPS - 1)) begin
               // Capture the completed word, including the group written this edge.
               out_state_d = st_d;
               fsm_d       = StDone;
            end else begin
               g_d = g_q + GW'(1);
            end
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) begin
               fsm_d = StIdle;
            end
         end
         default: begin
            fsm_d = StIdle;
         end
      endcase
   end

   assign out_state = out_state_q;
   assign busy      = (fsm_q != StIdle);

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Directed bench for sbox_layer_seq: default 4-lane instance plus 1- and 16-lane variants.
module tb_sbox_layer_seq;

   logic        clk;
   logic        rst;
   logic        in_valid, in_valid_s;
   logic [63:0] in_state;
   logic        out_ready;

   logic        in_ready, out_valid, sb_en, busy;
   logic [63:0] out_state;
   logic [15:0] sb_orig, sb_subst;

   logic        in_ready_a, out_valid_a, sb_en_a, busy_a;
   logic [63:0] out_state_a;
   logic [3:0]  sb_orig_a, sb_subst_a;

   logic        in_ready_b, out_valid_b, sb_en_b, busy_b;
   logic [63:0] out_state_b;
   logic [63:0] sb_orig_b, sb_subst_b;

   int total = 0;
   int bad   = 0;

   // Reference S-box lane.
   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
         4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
         4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
         4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
      endcase
   endfunction

   for (genvar k = 0; k < 4; k++) begin : g_lane_m
      assign sb_subst[4*k +: 4] = sbox(sb_orig[4*k +: 4]);
   end
   assign sb_subst_a = sbox(sb_orig_a);
   for (genvar k = 0; k < 16; k++) begin : g_lane_b
      assign sb_subst_b[4*k +: 4] = sbox(sb_orig_b[4*k +: 4]);
   end

   sbox_layer_seq #(.STATE_W(64), .LANES(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
      .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .sb_en(sb_en),
      .sb_orig(sb_orig), .sb_subst(sb_subst), .busy(busy)
   );

   sbox_layer_seq #(.STATE_W(64), .LANES(1)) u_dut_l1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_a), .in_state(in_state),
      .out_valid(out_valid_a), .out_ready(1'b1), .out_state(out_state_a), .sb_en(sb_en_a),
      .sb_orig(sb_orig_a), .sb_subst(sb_subst_a), .busy(busy_a)
   );

   sbox_layer_seq #(.STATE_W(64), .LANES(16)) u_dut_l16 (
      .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_b), .in_state(in_state),
      .out_valid(out_valid_b), .out_ready(1'b1), .out_state(out_state_b), .sb_en(sb_en_b),
      .sb_orig(sb_orig_b), .sb_subst(sb_subst_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] lane_exp [4];
   logic [63:0] outs [2];
   logic [63:0] res [3];
   int          acc [2];
   int          lat [3];
   int          n_acc, n_out;

   initial begin
      lane_exp = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_valid_s = 1'b0;
      in_state   = '0;
      out_ready  = 1'b1;
      step();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_sb_en", 64'(sb_en), 64'd0);
      check("rst_sb_orig", 64'(sb_orig), 64'd0);
      check("rst_out_state", out_state, 64'd0);
      rst = 1'b0;
      step();

      // Single block with lane visibility and latency.
      check("idle_sb_en", 64'(sb_en), 64'd0);
      in_valid = 1'b1;
      in_state = 64'h0123456789ABCDEF;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("run%0d_sb_en", i), 64'(sb_en), 64'd1);
         check($sformatf("run%0d_sb_orig", i), 64'(sb_orig), 64'(lane_exp[i]));
         check($sformatf("run%0d_out_valid", i), 64'(out_valid), 64'd0);
         check($sformatf("run%0d_in_ready", i), 64'(in_ready), 64'd0);
         step();
      end
      check("blk1_out_valid", 64'(out_valid), 64'd1);
      check("blk1_out_state", out_state, 64'hC56B90AD3EF84712);
      check("blk1_done_sb_en", 64'(sb_en), 64'd0);
      check("blk1_busy", 64'(busy), 64'd1);
      step();
      check("blk1_hs_out_valid", 64'(out_valid), 64'd0);
      check("blk1_hs_in_ready", 64'(in_ready), 64'd1);

      // Backpressure.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_state  = 64'h0;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_out_state", out_state, 64'hCCCCCCCCCCCCCCCC);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      check("bp_rel_out_valid", 64'(out_valid), 64'd0);
      check("bp_rel_in_ready", 64'(in_ready), 64'd1);

      // Back-to-back blocks with in_valid held high.
      in_valid = 1'b1;
      in_state = 64'hFFFFFFFFFFFFFFFF;
      n_acc    = 0;
      n_out    = 0;
      acc      = '{-100, 100};
      outs     = '{64'd0, 64'd0};
      for (int c = 0; c < 16; c++) begin
         if (in_ready && in_valid && n_acc < 2) begin
            acc[n_acc] = c;
            n_acc++;
         end
         if (out_valid && n_out < 2) begin
            outs[n_out] = out_state;
            n_out++;
         end
         step();
         if (n_acc == 1) in_state = 64'hAAAAAAAAAAAAAAAA;
         if (n_acc == 2) in_valid = 1'b0;
      end
      check("b2b_accept_gap", 64'(acc[1] - acc[0]), 64'd6);
      check("b2b_out0", outs[0], 64'h2222222222222222);
      check("b2b_out1", outs[1], 64'hFFFFFFFFFFFFFFFF);

      // Reset during the second RUN cycle.
      in_valid = 1'b1;
      in_state = 64'hFFFFFFFFFFFFFFFF;
      step();
      in_valid = 1'b0;
      step();
      check("mid_busy_pre", 64'(busy), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_in_ready", 64'(in_ready), 64'd1);
      check("mid_busy", 64'(busy), 64'd0);
      check("mid_out_valid", 64'(out_valid), 64'd0);
      check("mid_sb_orig", 64'(sb_orig), 64'd0);
      check("mid_sb_en", 64'(sb_en), 64'd0);
      check("mid_out_state", out_state, 64'd0);
      step();
      rst = 1'b0;
      step();

      // Post-reset block on all three lane widths.
      in_valid   = 1'b1;
      in_valid_s = 1'b1;
      in_state   = 64'h0123456789ABCDEF;
      step();
      in_valid   = 1'b0;
      in_valid_s = 1'b0;
      lat = '{0, 0, 0};
      res = '{64'd0, 64'd0, 64'd0};
      for (int c = 1; c <= 40; c++) begin
         step();
         if (out_valid && lat[0] == 0) begin lat[0] = c; res[0] = out_state; end
         if (out_valid_a && lat[1] == 0) begin lat[1] = c; res[1] = out_state_a; end
         if (out_valid_b && lat[2] == 0) begin lat[2] = c; res[2] = out_state_b; end
      end
      check("post_lat_l4", 64'(lat[0]), 64'd4);
      check("post_res_l4", res[0], 64'hC56B90AD3EF84712);
      check("sweep_lat_l1", 64'(lat[1]), 64'd16);
      check("sweep_res_l1", res[1], 64'hC56B90AD3EF84712);
      check("sweep_lat_l16", 64'(lat[2]), 64'd1);
      check("sweep_res_l16", res[2], 64'hC56B90AD3EF84712);
      check("sweep_idle_l1", 64'(in_ready_a), 64'd1);
      check("sweep_idle_l16", 64'(in_ready_b), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
